// File: rtl/pll_reset_sequencer.sv
// PLL power-up reset sequencer: holds the PLL in reset, waits for a stable
// lock with bounded retries, then releases downstream reset.
module pll_reset_sequencer #(
  parameter int RST_HOLD_CYCLES     = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic       soft_reset,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fault,
  output logic       lock_lost,
  output logic [1:0] retry_count
);

  localparam int MAX_AB =
    (RST_HOLD_CYCLES > LOCK_STABLE_CYCLES) ?
    RST_HOLD_CYCLES : LOCK_STABLE_CYCLES;
  localparam int MAXC =
    (MAX_AB > LOCK_TIMEOUT_CYCLES) ?
    MAX_AB : LOCK_TIMEOUT_CYCLES;
  localparam int CW = $clog2(MAXC + 1);

  localparam logic [CW-1:0] HOLD_LAST =
    CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] STAB_LAST =
    CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] TO_LAST =
    CW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [1:0] MAXR = 2'(MAX_RETRIES);

  typedef enum logic [2:0] {
    HOLD,
    WAIT_LOCK,
    STABLE,
    RUN,
    FAULT
  } state_t;

  state_t        state;
  state_t        state_n;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_n;
  logic [1:0]    retry_n;
  logic          lost_n;
  logic          enter;
  logic          meta;
  logic          locked_s;

  always_ff @(posedge refclk) begin
    if (rst) begin
      meta     <= 1'b0;
      locked_s <= 1'b0;
    end else begin
      meta     <= pll_locked;
      locked_s <= meta;
    end
  end

  always_comb begin
    state_n = state;
    retry_n = retry_count;
    lost_n  = lock_lost;
    if (soft_reset) begin
      state_n = HOLD;
      retry_n = 2'd0;
      lost_n  = 1'b0;
    end else begin
      unique case (state)
        HOLD: begin
          if (cnt == HOLD_LAST)
            state_n = WAIT_LOCK;
        end
        WAIT_LOCK: begin
          // Lock wins over a coincident timeout
          if (locked_s) begin
            state_n = STABLE;
          end else if (cnt == TO_LAST) begin
            if (retry_count < MAXR) begin
              state_n = HOLD;
              retry_n = retry_count + 2'd1;
            end else begin
              state_n = FAULT;
            end
          end
        end
        STABLE: begin
          if (!locked_s)
            state_n = WAIT_LOCK;
          else if (cnt == STAB_LAST)
            state_n = RUN;
        end
        RUN: begin
          if (!locked_s) begin
            state_n = HOLD;
            retry_n = 2'd0;
            lost_n  = 1'b1;
          end
        end
        FAULT: state_n = FAULT;
        default: state_n = HOLD;
      endcase
    end
  end

  // Saturating so the idle states never wrap
  always_comb begin
    enter = soft_reset || (state_n != state);
    if (enter)
      cnt_n = '0;
    else if (cnt == CNT_MAX)
      cnt_n = cnt;
    else
      cnt_n = cnt + 1'b1;
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= HOLD;
      cnt         <= '0;
      retry_count <= 2'd0;
      lock_lost   <= 1'b0;
      pll_rst     <= 1'b1;
      sys_rst     <= 1'b1;
      ready       <= 1'b0;
      fault       <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      retry_count <= retry_n;
      lock_lost   <= lost_n;
      pll_rst     <= (state_n == HOLD) ||
                     (state_n == FAULT);
      sys_rst     <= (state_n != RUN);
      ready       <= (state_n == RUN);
      fault       <= (state_n == FAULT);
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Scoreboard bench for pll_reset_sequencer: expected output vectors are
// queued per cycle index and compared when that cycle is reached.
module tb_pll_reset_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_locked = 1'b0;
  logic       soft_reset = 1'b0;
  logic       pll_rst;
  logic       sys_rst;
  logic       ready;
  logic       fault;
  logic       lock_lost;
  logic [1:0] retry_count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pll_reset_sequencer #(
    .RST_HOLD_CYCLES(4),
    .LOCK_STABLE_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(20),
    .MAX_RETRIES(2)
  ) dut (
    .refclk(clk),
    .rst(rst),
    .pll_locked(pll_locked),
    .soft_reset(soft_reset),
    .pll_rst(pll_rst),
    .sys_rst(sys_rst),
    .ready(ready),
    .fault(fault),
    .lock_lost(lock_lost),
    .retry_count(retry_count)
  );

  // {pll_rst, sys_rst, ready, fault}
  localparam logic [3:0] V_H = 4'b1100;
  localparam logic [3:0] V_W = 4'b0100;
  localparam logic [3:0] V_R = 4'b0010;
  localparam logic [3:0] V_F = 4'b1101;

  logic [6:0] obs;
  assign obs = {pll_rst, sys_rst, ready, fault,
                lock_lost, retry_count};

  typedef struct {
    int         cyc;
    string      name;
    logic [6:0] v;
  } exp_t;

  exp_t q[$];

  task automatic push(input int c, input string n,
                      input logic [3:0] st,
                      input logic lost,
                      input logic [1:0] rc);
    exp_t e;
    e.cyc  = c;
    e.name = n;
    e.v    = {st, lost, rc};
    q.push_back(e);
  endtask

  // Leaves time just after the last reset edge; the next edge is cycle 0
  task automatic do_reset();
    rst = 1'b1;
    soft_reset = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    q.delete();
    pll_locked = 1'b0;
    do_reset();
    push(0, "rst_c0", V_H, 1'b0, 2'd0);
    push(3, "rst_c3", V_H, 1'b0, 2'd0);
    push(4, "rst_c4", V_W, 1'b0, 2'd0);
    for (int k = 0; k <= 4; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = 1'b0;
    end
  endtask

  task automatic test_clean_lock();
    exp_t e;
    q.delete();
    pll_locked = 1'b1;
    do_reset();
    push(0,  "clean_c0",  V_H, 1'b0, 2'd0);
    push(3,  "clean_c3",  V_H, 1'b0, 2'd0);
    push(4,  "clean_c4",  V_W, 1'b0, 2'd0);
    push(5,  "clean_c5",  V_W, 1'b0, 2'd0);
    push(12, "clean_c12", V_W, 1'b0, 2'd0);
    push(13, "clean_c13", V_R, 1'b0, 2'd0);
    push(30, "clean_c30", V_R, 1'b0, 2'd0);
    for (int k = 0; k <= 30; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = 1'b1;
    end
  endtask

  task automatic test_no_lock();
    exp_t e;
    q.delete();
    pll_locked = 1'b0;
    do_reset();
    push(23,  "nl_c23",  V_W, 1'b0, 2'd0);
    push(24,  "nl_c24",  V_H, 1'b0, 2'd1);
    push(28,  "nl_c28",  V_W, 1'b0, 2'd1);
    push(47,  "nl_c47",  V_W, 1'b0, 2'd1);
    push(48,  "nl_c48",  V_H, 1'b0, 2'd2);
    push(71,  "nl_c71",  V_W, 1'b0, 2'd2);
    push(72,  "nl_c72",  V_F, 1'b0, 2'd2);
    push(500, "nl_c500", V_F, 1'b0, 2'd2);
    for (int k = 0; k <= 500; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = 1'b0;
    end
  endtask

  task automatic test_lock_glitch();
    exp_t e;
    q.delete();
    pll_locked = 1'b1;
    do_reset();
    push(10, "gl_c10", V_W, 1'b0, 2'd0);
    push(11, "gl_c11", V_W, 1'b0, 2'd0);
    push(19, "gl_c19", V_W, 1'b0, 2'd0);
    push(20, "gl_c20", V_R, 1'b0, 2'd0);
    push(25, "gl_c25", V_R, 1'b0, 2'd0);
    for (int k = 0; k <= 25; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = (k != 8);
    end
  endtask

  // Lock drop reaches the STABLE terminal cycle exactly
  task automatic test_stable_tie();
    exp_t e;
    q.delete();
    pll_locked = 1'b1;
    do_reset();
    push(13, "st_c13", V_W, 1'b0, 2'd0);
    push(21, "st_c21", V_W, 1'b0, 2'd0);
    push(22, "st_c22", V_R, 1'b0, 2'd0);
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = (k != 10);
    end
  endtask

  // Synchronized lock arrives on the timeout cycle
  task automatic test_timeout_tie();
    exp_t e;
    q.delete();
    pll_locked = 1'b0;
    do_reset();
    push(24, "tt_c24", V_W, 1'b0, 2'd0);
    push(31, "tt_c31", V_W, 1'b0, 2'd0);
    push(32, "tt_c32", V_R, 1'b0, 2'd0);
    for (int k = 0; k <= 32; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = (k >= 21);
    end
  endtask

  task automatic test_lock_loss();
    exp_t e;
    q.delete();
    pll_locked = 1'b0;
    do_reset();
    push(24, "ll_c24", V_H, 1'b0, 2'd1);
    push(37, "ll_c37", V_R, 1'b0, 2'd1);
    push(42, "ll_c42", V_R, 1'b0, 2'd1);
    push(43, "ll_c43", V_H, 1'b1, 2'd0);
    push(47, "ll_c47", V_W, 1'b1, 2'd0);
    push(55, "ll_c55", V_W, 1'b1, 2'd0);
    push(56, "ll_c56", V_R, 1'b1, 2'd0);
    push(60, "ll_c60", V_R, 1'b1, 2'd0);
    for (int k = 0; k <= 60; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = (k >= 26 && k < 40) || (k >= 45);
    end
  endtask

  task automatic test_fault_recovery();
    exp_t e;
    q.delete();
    pll_locked = 1'b1;
    do_reset();
    push(13,  "fr_c13",  V_R, 1'b0, 2'd0);
    push(19,  "fr_c19",  V_H, 1'b1, 2'd0);
    push(43,  "fr_c43",  V_H, 1'b1, 2'd1);
    push(67,  "fr_c67",  V_H, 1'b1, 2'd2);
    push(90,  "fr_c90",  V_W, 1'b1, 2'd2);
    push(91,  "fr_c91",  V_F, 1'b1, 2'd2);
    push(95,  "fr_c95",  V_F, 1'b1, 2'd2);
    push(96,  "fr_soft", V_H, 1'b0, 2'd0);
    push(120, "fr_c120", V_H, 1'b0, 2'd1);
    push(125, "fr_c125", V_W, 1'b0, 2'd1);
    push(126, "fr_both", V_H, 1'b0, 2'd0);
    for (int k = 0; k <= 126; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = (k < 16);
      soft_reset = (k == 95) || (k == 125);
      rst = (k == 125);
    end
  endtask

  task automatic test_reset_mid_stable();
    exp_t e;
    q.delete();
    pll_locked = 1'b1;
    do_reset();
    push(8,  "rm_c8",  V_W, 1'b0, 2'd0);
    push(9,  "rm_c9",  V_H, 1'b0, 2'd0);
    push(12, "rm_c12", V_H, 1'b0, 2'd0);
    push(13, "rm_c13", V_W, 1'b0, 2'd0);
    push(21, "rm_c21", V_W, 1'b0, 2'd0);
    push(22, "rm_c22", V_R, 1'b0, 2'd0);
    for (int k = 0; k <= 22; k++) begin
      @(negedge clk);
      while (q.size() > 0 && q[0].cyc == k) begin
        e = q.pop_front();
        checks++;
        if (obs !== e.v) begin
          errors++;
          $display("FAIL %s cyc %0d got %b want %b",
                   e.name, k, obs, e.v);
        end
      end
      pll_locked = 1'b1;
      rst = (k == 8);
    end
  endtask

  task automatic test_drain();
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain left %0d want 0", q.size());
    end
  endtask

  initial begin
    test_reset();
    test_drain();
    test_clean_lock();
    test_drain();
    test_no_lock();
    test_drain();
    test_lock_glitch();
    test_drain();
    test_stable_tie();
    test_drain();
    test_timeout_tie();
    test_drain();
    test_lock_loss();
    test_drain();
    test_fault_recovery();
    test_drain();
    test_reset_mid_stable();
    test_drain();
    rst = 1'b0;
    soft_reset = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
